// File: rtl/dmem_banked.sv
// Banked word-addressed data memory with valid/ready handshake, fixed access latency,
// range-error reporting and zero-fill after reset. Define DMEM_BANKED_BYTE_EN_EN for byte strobes.
module dmem_banked #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned BANK_DEPTH = 256,
    parameter int unsigned ACCESS_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 readwrite,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    dataIn,
`ifdef DMEM_BANKED_BYTE_EN_EN
    input  logic [DATA_W/8-1:0]  wstrb,
`endif
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_W-1:0]    dataOut,
    output logic                 resp_err,
    output logic [NUM_BANKS-1:0] bank_active,
    output logic                 busy
);

    localparam int unsigned OFF_W  = $clog2(BANK_DEPTH);
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned LAT_W  = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ACCESS_LAT - 1);
    localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(BANK_DEPTH - 1);
    localparam logic [63:0] TOTAL_WORDS = 64'(NUM_BANKS) * 64'(BANK_DEPTH);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [OFF_W-1:0]    init_idx;
    logic [LAT_W-1:0]    lat_cnt;
    logic                rw_q;
    logic                oor_q;
    logic [BANK_W-1:0]   bank_q;
    logic [OFF_W-1:0]    off_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   wr_word;
    logic                accept;
    logic                commit;

    logic [DATA_W-1:0]   mem [NUM_BANKS][BANK_DEPTH];

    assign accept = (state_q == S_IDLE) && req_valid;
    assign commit = (state_q == S_ACCESS) && (lat_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   if (init_idx == LAST_IDX) state_d = S_IDLE;
            S_IDLE:   if (req_valid)            state_d = S_ACCESS;
            S_ACCESS: if (lat_cnt == '0)        state_d = S_RESP;
            S_RESP:   if (resp_ready)           state_d = S_IDLE;
            default:                            state_d = S_INIT;
        endcase
    end

    always_comb begin
        req_ready   = 1'b0;
        busy        = 1'b0;
        resp_valid  = 1'b0;
        bank_active = '0;
        case (state_q)
            S_INIT:   busy = 1'b1;
            S_IDLE:   req_ready = 1'b1;
            S_ACCESS: begin
                busy = 1'b1;
                if (!oor_q) bank_active = NUM_BANKS'(1) << bank_q;
            end
            S_RESP:   resp_valid = 1'b1;
            default:  busy = 1'b1;
        endcase
    end

`ifdef DMEM_BANKED_BYTE_EN_EN
    logic [DATA_W/8-1:0] wstrb_q;

    // Read-modify-write merge of strobed bytes into the addressed word
    always_comb begin
        wr_word = mem[bank_q][off_q];
        for (int i = 0; i < DATA_W/8; i++) begin
            if (wstrb_q[i]) wr_word[i*8 +: 8] = wdata_q[i*8 +: 8];
        end
    end
`else
    assign wr_word = wdata_q;
`endif

    // Request capture, latency countdown and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_idx <= '0;
            lat_cnt  <= '0;
            rw_q     <= 1'b0;
            oor_q    <= 1'b0;
            bank_q   <= '0;
            off_q    <= '0;
            wdata_q  <= '0;
            dataOut  <= '0;
            resp_err <= 1'b0;
`ifdef DMEM_BANKED_BYTE_EN_EN
            wstrb_q  <= '0;
`endif
        end else begin
            if (state_q == S_INIT) init_idx <= init_idx + OFF_W'(1);
            if (accept) begin
                rw_q    <= readwrite;
                oor_q   <= !(64'(addr) < TOTAL_WORDS);
                bank_q  <= BANK_W'(addr >> OFF_W);
                off_q   <= OFF_W'(addr);
                wdata_q <= dataIn;
                lat_cnt <= LAT_LOAD;
`ifdef DMEM_BANKED_BYTE_EN_EN
                wstrb_q <= wstrb;
`endif
            end
            if (state_q == S_ACCESS && lat_cnt != '0) lat_cnt <= lat_cnt - LAT_W'(1);
            if (commit) begin
                dataOut  <= (!rw_q && !oor_q) ? mem[bank_q][off_q] : '0;
                resp_err <= oor_q;
            end
            if (state_q == S_RESP && resp_ready) resp_err <= 1'b0;
        end
    end

    // Storage: parallel zero-fill during INIT, single write at the commit edge
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            for (int b = 0; b < NUM_BANKS; b++) mem[b][init_idx] <= '0;
        end else if (commit && rw_q && !oor_q) begin
            mem[bank_q][off_q] <= wr_word;
        end
    end

endmodule

// File: tb/tb_dmem_banked.sv
// Self-checking bench for dmem_banked: directed scenarios plus randomized traffic,
// checked by a queue-based scoreboard against a flat-array memory model.
module tb_dmem_banked;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned NB  = 4;
    localparam int unsigned BD  = 256;
    localparam int unsigned LAT = 2;
    localparam int unsigned TOT = NB * BD;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          readwrite;
    logic [AW-1:0] addr;
    logic [DW-1:0] dataIn;
    logic [3:0]    wstrb;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] dataOut;
    logic          resp_err;
    logic [NB-1:0] bank_active;
    logic          busy;

    int errors = 0;
    int checks = 0;
    bit rand_rr = 1'b0;

    logic [31:0] model [TOT];
    logic [31:0] exp_d [$];
    logic        exp_e [$];

    always #5 clk = ~clk;

    dmem_banked #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB), .BANK_DEPTH(BD), .ACCESS_LAT(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .readwrite(readwrite),
        .addr(addr),
        .dataIn(dataIn),
`ifdef DMEM_BANKED_BYTE_EN_EN
        .wstrb(wstrb),
`endif
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .dataOut(dataOut),
        .resp_err(resp_err),
        .bank_active(bank_active),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = d;
`ifdef DMEM_BANKED_BYTE_EN_EN
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
`endif
        return r;
    endfunction

    // Consumer handshake pacing
    always @(posedge clk) begin
        if (rand_rr) #1 resp_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: every response handshake pops one expectation
    always @(negedge clk) begin
        logic [31:0] d;
        logic        e;
        if (!reset && resp_valid && resp_ready) begin
            if (exp_d.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                d = exp_d.pop_front();
                e = exp_e.pop_front();
                chk("resp_data", 64'(dataOut), 64'(d));
                chk("resp_err", 64'(resp_err), 64'(e));
            end
        end
    end

    task automatic apply_reset();
        int n;
        reset     = 1'b1;
        req_valid = 1'b0;
        exp_d.delete();
        exp_e.delete();
        for (int i = 0; i < TOT; i++) model[i] = 32'd0;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_dataOut", 64'(dataOut), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_bank_active", 64'(bank_active), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        n = 0;
        while (1) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (req_ready || n > int'(BD) + 20) break;
        end
        chk("init_edges", 64'(n), 64'(BD));
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic rw, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int waited);
        logic [31:0] ed;
        logic        ee;
        logic [3:0]  eb;
        req_valid = 1'b1;
        readwrite = rw;
        addr      = a;
        dataIn    = d;
        wstrb     = s;
        waited    = 0;
        while (1) begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
            if (waited > 2000) begin
                chk("accept_timeout", 64'd0, 64'd1);
                req_valid = 1'b0;
                return;
            end
        end
        if (a >= TOT) begin
            ed = 32'd0; ee = 1'b1; eb = 4'd0;
        end else begin
            ee = 1'b0;
            eb = 4'(1 << (a / BD));
            if (rw) begin
                model[a] = merge(model[a], d, s);
                ed = 32'd0;
            end else begin
                ed = model[a];
            end
        end
        @(posedge clk);
        exp_d.push_back(ed);
        exp_e.push_back(ee);
        #1;
        req_valid = 1'b0;
        readwrite = 1'($urandom);
        addr      = $urandom;
        dataIn    = $urandom;
        wstrb     = 4'($urandom);
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            chk("resp_valid_early", 64'(resp_valid), 64'd0);
            if (i == 0) begin
                chk("bank_active", 64'(bank_active), 64'(eb));
                chk("busy_access", 64'(busy), 64'd1);
                chk("req_ready_access", 64'(req_ready), 64'd0);
            end
        end
        @(negedge clk);
        chk("resp_valid_latency", 64'(resp_valid), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        int n;
        logic [31:0] a;
        reset      = 1'b1;
        req_valid  = 1'b0;
        readwrite  = 1'b0;
        addr       = '0;
        dataIn     = '0;
        wstrb      = 4'hf;
        resp_ready = 1'b1;

        apply_reset();
        rand_rr = 1'b1;

        do_req(1'b0, 32'd7, 32'd0, 4'hf, w);
        do_req(1'b1, 32'd7, 32'd20, 4'hf, w);
        do_req(1'b0, 32'd7, 32'd0, 4'hf, w);

        do_req(1'b1, 32'd256, 32'hDEADBEEF, 4'hf, w);
        do_req(1'b1, 32'd1023, 32'h12345678, 4'hf, w);
        do_req(1'b0, 32'd256, 32'd0, 4'hf, w);
        do_req(1'b0, 32'd1023, 32'd0, 4'hf, w);
        do_req(1'b0, 32'd0, 32'd0, 4'hf, w);

        do_req(1'b1, 32'd1024, 32'hCAFEF00D, 4'hf, w);
        do_req(1'b0, 32'd1023, 32'd0, 4'hf, w);

        // Back-pressure: response held, new request waits for the handshake
        rand_rr = 1'b0;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        do_req(1'b0, 32'd7, 32'd0, 4'hf, w);
        req_valid = 1'b1;
        readwrite = 1'b0;
        addr      = 32'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_resp_valid", 64'(resp_valid), 64'd1);
            chk("stall_dataOut", 64'(dataOut), 64'd20);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        do_req(1'b0, 32'd0, 32'd0, 4'hf, w);
        chk("accept_after_handshake", 64'(w), 64'd1);
        rand_rr = 1'b1;

        // Reset in the first ACCESS cycle abandons the write
        req_valid = 1'b1;
        readwrite = 1'b1;
        addr      = 32'd3;
        dataIn    = 32'd55;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        apply_reset();
        do_req(1'b0, 32'd3, 32'd0, 4'hf, w);

`ifdef DMEM_BANKED_BYTE_EN_EN
        do_req(1'b1, 32'd9, 32'hFFFFFFFF, 4'hf, w);
        do_req(1'b1, 32'd9, 32'h00000000, 4'b0010, w);
        do_req(1'b1, 32'd9, 32'h00000000, 4'b0000, w);
        do_req(1'b0, 32'd9, 32'd0, 4'b0000, w);
`endif

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       a = TOT + $urandom_range(0, 63);
                1:       a = $urandom | 32'h8000_0000;
                default: a = $urandom_range(0, TOT - 1);
            endcase
            do_req(1'($urandom), a, $urandom, 4'($urandom), w);
        end

        rand_rr = 1'b0;
        @(posedge clk);
        #1 resp_ready = 1'b1;
        n = 0;
        while (exp_d.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        chk("queue_drained", 64'(exp_d.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
